// File: rtl/ws2812_chain_driver_if.sv
// Pixel stream handshake into the WS2812 chain driver.
// The source drives pixel/valid, the driver answers with ready.
interface ws2812_chain_driver_if #(
    parameter int BITS_PER_LED = 24
);
    logic [BITS_PER_LED-1:0] pixel_in;
    logic                    pixel_valid_in;
    logic                    pixel_ready_out;

    modport master (
        output pixel_in,
        output pixel_valid_in,
        input  pixel_ready_out
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid_in,
        output pixel_ready_out
    );
endinterface

// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: serialises NUM_LEDS pixels MSB first as
// high/low pulse pairs, then holds the line low to latch the chain.
module ws2812_chain_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T0H          = 40,
    parameter int T0L          = 85,
    parameter int T1H          = 80,
    parameter int T1L          = 45,
    parameter int RESET_CYCLES = 5000
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic                      continuous_in,
    ws2812_chain_driver_if.slave      pix,
    output logic                      data_out,
    output logic [$clog2(NUM_LEDS):0] led_index_out,
    output logic                      busy_out,
    output logic                      frame_done_out,
    output logic                      underflow_out
);

    localparam int IW   = $clog2(NUM_LEDS) + 1;
    localparam int BW   = $clog2(BITS_PER_LED + 1);
    localparam int TMH  = (T0H > T1H) ? T0H : T1H;
    localparam int TML  = (T0L > T1L) ? T0L : T1L;
    localparam int TMB  = (TMH > TML) ? TMH : TML;
    localparam int TMAX = (TMB > RESET_CYCLES) ? TMB : RESET_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] T0H_M = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_M = CW'(T0L - 1);
    localparam logic [CW-1:0] T1H_M = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_M = CW'(T1L - 1);
    localparam logic [CW-1:0] RC_M  = CW'(RESET_CYCLES - 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_LED - 1);
    localparam logic [IW-1:0] LAST_LED = IW'(NUM_LEDS - 1);
    localparam logic [IW-1:0] N_LEDS   = IW'(NUM_LEDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_e;

    state_e                  state_q, state_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BITS_PER_LED-1:0] shadow_q, shadow_d;
    logic                    shadow_full_q, shadow_full_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           claim_q, claim_d;
    logic                    under_q, under_d;
    logic                    data_q, data_d;

    logic busy;
    logic ready;
    logic xfer;
    logic cur_bit;
    logic high_end;
    logic low_end;
    logic last_bit;
    logic last_led;
    logic latch_end;

    // claim_q counts slots taken this frame, by real pixels or by zero fills,
    // so a late pixel lands in the slot after a zero-filled one.
    assign busy      = (state_q != S_IDLE);
    assign ready     = busy && !shadow_full_q && (claim_q < N_LEDS);
    assign xfer      = pix.pixel_valid_in && ready;
    assign cur_bit   = shift_q[BITS_PER_LED-1];
    assign high_end  = (cnt_q == (cur_bit ? T1H_M : T0H_M));
    assign low_end   = (cnt_q == (cur_bit ? T1L_M : T0L_M));
    assign last_bit  = (bit_q == LAST_BIT);
    assign last_led  = (idx_q == LAST_LED);
    assign latch_end = (cnt_q == RC_M);

    assign pix.pixel_ready_out = ready;
    assign data_out            = data_q;
    assign led_index_out       = idx_q;
    assign busy_out            = busy;
    assign frame_done_out      = (state_q == S_LATCH) && latch_end;
    assign underflow_out       = under_q;

    // Next-state logic for the frame sequencer and its datapath.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        bit_d         = bit_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        claim_d       = claim_q;
        under_d       = under_q;

        if (xfer) begin
            claim_d = claim_q + IW'(1);
        end

        if (xfer && (state_q == S_HIGH || state_q == S_LOW)) begin
            shadow_d      = pix.pixel_in;
            shadow_full_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_FETCH;
                    under_d = 1'b0;
                    claim_d = '0;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                if (xfer) begin
                    shift_d = pix.pixel_in;
                    idx_d   = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (high_end) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOW: begin
                if (!low_end) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!last_bit) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + BW'(1);
                    shift_d = shift_q << 1;
                    state_d = S_HIGH;
                end else if (last_led) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end else begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    idx_d   = idx_q + IW'(1);
                    state_d = S_HIGH;
                    if (shadow_full_q) begin
                        shift_d       = shadow_q;
                        shadow_full_d = 1'b0;
                    end else if (xfer) begin
                        shift_d       = pix.pixel_in;
                        shadow_full_d = 1'b0;
                    end else begin
                        shift_d = '0;
                        under_d = 1'b1;
                        claim_d = claim_q + IW'(1);
                    end
                end
            end
            S_LATCH: begin
                if (latch_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    claim_d = '0;
                    state_d = continuous_in ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_d = (state_d == S_HIGH);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            bit_q         <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            claim_q       <= '0;
            under_q       <= 1'b0;
            data_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            bit_q         <= bit_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            claim_q       <= claim_d;
            under_q       <= under_d;
            data_q        <= data_d;
        end
    end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: random pixels, pulse-width decoding
// against a bit-level model of the expected line waveform.
module tb_ws2812_chain_driver;

    localparam int NL  = 2;
    localparam int BPL = 4;
    localparam int T0H = 2;
    localparam int T0L = 4;
    localparam int T1H = 4;
    localparam int T1L = 2;
    localparam int RC  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic dout;
    logic busy;
    logic fdone;
    logic uf;
    logic [$clog2(NL):0] lidx;

    ws2812_chain_driver_if #(.BITS_PER_LED(BPL)) pif ();

    ws2812_chain_driver #(
        .NUM_LEDS(NL), .BITS_PER_LED(BPL),
        .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
        .RESET_CYCLES(RC)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .start_in(start),
        .continuous_in(cont),
        .pix(pif.slave),
        .data_out(dout),
        .led_index_out(lidx),
        .busy_out(busy),
        .frame_done_out(fdone),
        .underflow_out(uf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // line monitor: rise cycles, high widths, frame_done cycles
    int rise_q[$];
    int w_q[$];
    int fd_q[$];
    int xf_q[$];
    int hw = 0;
    logic prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (dout === 1'b1) begin
            if (!prev) rise_q.push_back(cyc);
            hw++;
        end else if (prev) begin
            w_q.push_back(hw);
            hw = 0;
        end
        prev = (dout === 1'b1);
        if (fdone === 1'b1) fd_q.push_back(cyc);
    end

    // pixel source
    logic [BPL-1:0] src_q[$];
    bit hold = 1'b1;
    bit pend = 1'b0;

    initial begin
        pif.pixel_valid_in = 1'b0;
        pif.pixel_in = '0;
        forever begin
            @(negedge clk);
            if (pend && src_q.size() > 0) void'(src_q.pop_front());
            if (!hold && src_q.size() > 0) begin
                pif.pixel_valid_in = 1'b1;
                pif.pixel_in = src_q[0];
            end else begin
                pif.pixel_valid_in = 1'b0;
            end
            pend = pif.pixel_valid_in && (pif.pixel_ready_out === 1'b1);
            if (pend) xf_q.push_back(cyc);
        end
    end

    // model: each bit is a high of T1H/T0H then a low of T1L/T0L
    function automatic int hi_w(input logic b);
        return b ? T1H : T0H;
    endfunction

    function automatic int per_w(input logic b);
        return b ? (T1H + T1L) : (T0H + T0L);
    endfunction

    function automatic int frame_len(input logic [BPL-1:0] px[$],
                                     input int f);
        int s = RC;
        for (int p = f * NL; p < f * NL + NL; p++)
            for (int b = BPL - 1; b >= 0; b--)
                s += per_w(px[p][b]);
        return s;
    endfunction

    task automatic check_frames(input string tg,
                                input logic [BPL-1:0] px[$]);
        int n = 0;
        int pp = 0;
        chk({tg, "_nbits"}, w_q.size(), px.size() * BPL);
        chk({tg, "_fd_seen"}, fd_q.size() > 0, 1);
        if (fd_q.size() > 0 && rise_q.size() > 0)
            chk({tg, "_frame_len"}, fd_q[0] - rise_q[0] + 1,
                frame_len(px, 0));
        for (int p = 0; p < px.size(); p++) begin
            for (int b = BPL - 1; b >= 0; b--) begin
                if (n < w_q.size())
                    chk({tg, "_hiwidth"}, w_q[n], hi_w(px[p][b]));
                if (n > 0 && (n % (NL * BPL)) != 0 && n < rise_q.size())
                    chk({tg, "_period"}, rise_q[n] - rise_q[n-1], pp);
                pp = per_w(px[p][b]);
                n++;
            end
        end
        w_q.delete();
        rise_q.delete();
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fd(input string tg);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fdone !== 1'b1 && n < 2000);
        chk({tg, "_fd_timeout"}, fdone === 1'b1, 1);
    endtask

    logic [BPL-1:0] exp_q[$];
    logic [BPL-1:0] r0, r1, rl;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pif.pixel_ready_out, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_uf", uf, 0);
        chk("rst_idx", lidx, 0);
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (2) @(negedge clk);

        // basic frame 0xA, 0x5
        exp_q = '{4'hA, 4'h5};
        src_q.push_back(4'hA);
        src_q.push_back(4'h5);
        fd_q.delete();
        start_frame();
        wait_fd("t1");
        @(negedge clk);
        chk("t1_busy_off", busy, 0);
        chk("t1_uf", uf, 0);
        check_frames("t1", exp_q);

        // underflow: second pixel missing, late one goes to next frame
        r0 = BPL'($urandom);
        src_q.push_back(r0);
        fd_q.delete();
        start_frame();
        repeat (32) @(negedge clk);
        rl = BPL'($urandom);
        src_q.push_back(rl);
        wait_fd("t2");
        @(negedge clk);
        chk("t2_uf_set", uf, 1);
        exp_q = '{r0, 4'h0};
        check_frames("t2", exp_q);
        repeat (10) @(negedge clk);
        chk("t2_uf_sticky", uf, 1);
        chk("t2_busy_off", busy, 0);

        r1 = BPL'($urandom);
        src_q.push_back(r1);
        fd_q.delete();
        start_frame();
        chk("t3_uf_clr", uf, 0);
        wait_fd("t3");
        @(negedge clk);
        exp_q = '{rl, r1};
        check_frames("t3", exp_q);

        // start during HIGH is ignored
        r0 = BPL'($urandom);
        r1 = BPL'($urandom);
        src_q.push_back(r0);
        src_q.push_back(r1);
        fd_q.delete();
        start_frame();
        for (int n = 0; n < 100 && dout !== 1'b1; n++) @(negedge clk);
        chk("t4_high_seen", dout, 1);
        start_frame();
        wait_fd("t4");
        @(negedge clk);
        chk("t4_busy_off", busy, 0);
        exp_q = '{r0, r1};
        check_frames("t4", exp_q);
        repeat (20) @(negedge clk);
        chk("t4_no_refire", rise_q.size(), 0);
        chk("t4_idle", busy, 0);

        // reset during second pixel
        src_q.push_back(BPL'($urandom));
        src_q.push_back(BPL'($urandom));
        start_frame();
        for (int n = 0; n < 100 && lidx !== 1; n++) @(negedge clk);
        chk("t5_led1", lidx, 1);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_dout", dout, 0);
        chk("t5_busy", busy, 0);
        chk("t5_idx", lidx, 0);
        chk("t5_ready", pif.pixel_ready_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        src_q.delete();
        w_q.delete();
        rise_q.delete();
        hold = 1'b0;
        repeat (80) @(negedge clk);
        chk("t5_silent", rise_q.size(), 0);
        chk("t5_idle", busy, 0);

        // FETCH waits of random length
        for (int it = 0; it < 4; it++) begin
            int dly;
            dly = (it == 0) ? 20 : int'($urandom_range(3, 30));
            hold = 1'b1;
            r0 = BPL'($urandom);
            r1 = BPL'($urandom);
            src_q.push_back(r0);
            src_q.push_back(r1);
            fd_q.delete();
            start_frame();
            repeat (dly) @(negedge clk);
            chk("t6_wait_low", rise_q.size(), 0);
            chk("t6_wait_busy", busy, 1);
            xf_q.delete();
            hold = 1'b0;
            wait_fd("t6");
            @(negedge clk);
            chk("t6_first_high",
                rise_q.size() > 0 ? rise_q[0] : -1,
                xf_q.size() > 0 ? xf_q[0] + 1 : -2);
            exp_q = '{r0, r1};
            check_frames("t6", exp_q);
        end

        // continuous mode: three back-to-back frames
        cont = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3 * NL; i++) begin
            r0 = BPL'($urandom);
            exp_q.push_back(r0);
            src_q.push_back(r0);
        end
        fd_q.delete();
        start_frame();
        wait_fd("t7a");
        wait_fd("t7b");
        repeat (2) @(negedge clk);
        cont = 1'b0;
        wait_fd("t7c");
        @(negedge clk);
        chk("t7_busy_off", busy, 0);
        chk("t7_nframes", fd_q.size(), 3);
        if (fd_q.size() == 3) begin
            chk("t7_gap1", fd_q[1] - fd_q[0], frame_len(exp_q, 1) + 1);
            chk("t7_gap2", fd_q[2] - fd_q[1], frame_len(exp_q, 2) + 1);
        end
        check_frames("t7", exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2812_chain_driver.md
WS2812_CHAIN_DRIVER -- requirements
Module: ws2812_chain_driver

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, number of pixels per frame (>=1).
REQ-002 The block SHALL have parameter BITS_PER_LED, default 24, bits per pixel (24 = GRB, 32 = GRBW).
REQ-003 The block SHALL have parameters T0H/T0L/T1H/T1L, defaults 40/85/80/45, high/low phase lengths in clk_in cycles for 0-bit and 1-bit.
REQ-004 The block SHALL have parameter RESET_CYCLES, default 5000, latch-low length in clk_in cycles.
REQ-005 clk_in  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 rst_n_in  input  1  reset, synchronous, active-low.
REQ-007 start_in  input  1  single-cycle request to begin a frame.
REQ-008 continuous_in  input  1  when high, a new frame starts automatically after each latch period.
REQ-009 pixel_in  input  BITS_PER_LED  pixel data, MSB transmitted first.
REQ-010 pixel_valid_in  input  1  pixel_in holds a valid pixel.
REQ-011 pixel_ready_out  output  1  block accepts pixel_in this cycle; transfer when valid and ready both high.
REQ-012 data_out  output  1  serial line to the first LED.
REQ-013 led_index_out  output  $clog2(NUM_LEDS)+1  index of pixel currently being transmitted.
REQ-014 busy_out  output  1  high from frame start until the latch period ends.
REQ-015 frame_done_out  output  1  one-cycle pulse at end of latch period.
REQ-016 underflow_out  output  1  sticky flag: a pixel was needed but none had been accepted.

Function
REQ-017 States SHALL be IDLE, FETCH, HIGH, LOW, LATCH.
REQ-018 IDLE: data_out=0, busy_out=0; start_in=1 -> FETCH next cycle; busy_out=1 from that cycle.
REQ-019 The block SHALL hold a one-pixel shadow register; pixel_ready_out=1 exactly when the shadow is empty, busy_out=1, and fewer than NUM_LEDS pixels have been accepted this frame.
REQ-020 FETCH: data_out=0; waits without limit for the first pixel; on transfer the pixel moves to the shift register, led_index_out=0, -> HIGH next cycle.
REQ-021 HIGH: data_out=1 for exactly T1H (bit=1) or T0H (bit=0) cycles, then -> LOW.
REQ-022 LOW: data_out=0 for exactly T1L or T0L cycles; then next bit -> HIGH with no gap cycle.
REQ-023 After the last bit of a pixel, if pixels remain: shadow full -> shadow loads shift register, led_index_out increments, -> HIGH with no gap; shadow empty -> all-zero pixel is sent instead, underflow_out set, and that pixel slot counts as consumed.
REQ-024 A pixel accepted after its slot was replaced by zeros SHALL be applied to the next slot, not the replaced one.
REQ-025 After the last bit of pixel NUM_LEDS-1 -> LATCH: data_out=0 for exactly RESET_CYCLES cycles.
REQ-026 End of LATCH: frame_done_out=1 for one cycle; continuous_in=1 -> FETCH, else -> IDLE.
REQ-027 start_in while busy_out=1 SHALL be ignored (not queued).
REQ-028 underflow_out SHALL clear only on reset or on start_in accepted in IDLE.
REQ-029 Each bit period SHALL be exactly THigh+TLow cycles; a frame with no underflow and no FETCH wait lasts NUM_LEDS*BITS_PER_LED bit periods plus RESET_CYCLES.
REQ-030 Phase counters SHALL be wide enough for max(all timing parameters) without wrap.

Reset
REQ-031 rst_n_in=0 at a rising edge SHALL, on that edge, force state IDLE, data_out=0, pixel_ready_out=0, busy_out=0, frame_done_out=0, underflow_out=0, led_index_out=0, shadow empty.
REQ-032 Reset mid-frame SHALL abort transmission immediately; no further pulses on data_out until a new start_in.

Verification (bench params NUM_LEDS=2, BITS_PER_LED=4, T0H=2, T0L=4, T1H=4, T1L=2, RESET_CYCLES=10)
REQ-033 start_in pulse, pixels 0xA then 0x5 offered valid -> data_out high widths 4,2,4,2,2,4,2,4 cycles, each bit period 6 cycles, then 10 low cycles, frame_done_out one pulse, IDLE.
REQ-034 Second pixel withheld -> second slot transmits 0x0 (four 2-cycle highs), underflow_out=1 and stays high until next accepted start_in.
REQ-035 continuous_in=1, pixels always valid -> frame_done_out pulses every 2*4*6+10=58 cycles after the first frame, no idle gap beyond FETCH accept cycle.
REQ-036 start_in pulsed during HIGH of first frame -> no second frame; busy_out falls right after frame_done_out.
REQ-037 rst_n_in=0 held one cycle during second pixel -> next cycle data_out=0, busy_out=0, led_index_out=0; no pulses until new start_in.
REQ-038 pixel_valid_in delayed 20 cycles after start_in -> data_out stays 0 for the wait, first HIGH begins the cycle after transfer.
